// File: rtl/config_loader.sv
// Initiator side of the config_mem write port: collects num_inputs+1 words from a
// valid/ready stream, then runs the write_en/write_rdy/write_ack commit handshake.

module config_word_reg #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);
    always_ff @(posedge clk) begin
        if (!reset)    q <= '0;
        else if (load) q <= d;
    end
endmodule

module config_loader #(
    parameter int width       = 16,
    parameter int num_inputs  = 8,
    parameter int ack_timeout = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             cfg_valid,
    input  logic [width-1:0]                 cfg_data,
    output logic                             cfg_ready,
    output logic                             write_en,
    input  logic                             write_rdy,
    input  logic                             write_ack,
    output logic [num_inputs:0][width-1:0]   w_data_out,
    output logic                             busy,
    output logic                             done,
    output logic                             error
);
    localparam int CW = (num_inputs > 0) ? $clog2(num_inputs + 1) : 1;
    localparam int TW = (ack_timeout > 1) ? $clog2(ack_timeout) : 1;
    localparam logic [CW-1:0] LAST    = CW'(num_inputs);
    localparam logic [TW-1:0] TO_LAST = TW'((ack_timeout > 0) ? ack_timeout - 1 : 0);

    typedef enum logic [1:0] {IDLE, COLLECT, WAIT_RDY, WRITE} state_t;

    state_t          state, nxt;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   tcnt;
    logic            take, ack_ok, to_hit;
    logic [num_inputs:0] load;

    always_comb begin
        nxt    = state;
        take   = 1'b0;
        ack_ok = 1'b0;
        to_hit = 1'b0;
        case (state)
            IDLE:     if (start) nxt = COLLECT;
            COLLECT: begin
                if (cfg_valid && cfg_ready) begin
                    take = 1'b1;
                    if (cnt == LAST) nxt = WAIT_RDY;
                end
            end
            WAIT_RDY: if (write_rdy) nxt = WRITE;
            WRITE: begin
                // ack takes priority over a timeout landing on the same cycle
                if (write_ack) begin
                    ack_ok = 1'b1;
                    nxt    = IDLE;
                end else if (ack_timeout != 0 && tcnt == TO_LAST) begin
                    to_hit = 1'b1;
                    nxt    = IDLE;
                end
            end
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cfg_ready <= 1'b0;
            write_en  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            cnt       <= '0;
            tcnt      <= '0;
        end else begin
            state     <= nxt;
            cfg_ready <= (nxt == COLLECT);
            write_en  <= (nxt == WRITE);
            busy      <= (nxt != IDLE);
            done      <= ack_ok;
            if (state == IDLE && start) begin
                error <= 1'b0;
                cnt   <= '0;
            end else begin
                if (to_hit) error <= 1'b1;
                if (take && cnt != LAST) cnt <= cnt + CW'(1);
            end
            tcnt <= (state == WRITE && nxt == WRITE) ? tcnt + TW'(1) : '0;
        end
    end

    // one register per frame word; words only load in COLLECT, so they are frozen in WRITE
    for (genvar i = 0; i <= num_inputs; i++) begin : g_word
        assign load[i] = take && (cnt == CW'(i));
        config_word_reg #(.width(width)) u_word (
            .clk   (clk),
            .reset (reset),
            .load  (load[i]),
            .d     (cfg_data),
            .q     (w_data_out[i])
        );
    end
endmodule

// File: tb/tb_config_loader.sv
// Randomized directed bench for config_loader with a transaction-level outcome model.

module tb_config_loader;
    localparam int W  = 16;
    localparam int N  = 8;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic cfg_valid = 1'b0;
    logic [W-1:0] cfg_data = '0;
    logic cfg_ready, write_en, busy, done, error;
    logic write_rdy = 1'b0;
    logic write_ack = 1'b0;
    logic [N:0][W-1:0] w_data_out;

    int total = 0;
    int passed = 0;

    config_loader #(.width(W), .num_inputs(N), .ack_timeout(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready),
        .write_en   (write_en),
        .write_rdy  (write_rdy),
        .write_ack  (write_ack),
        .w_data_out (w_data_out),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        total++;
        assert (obs == exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_w(input string tag, input logic [N:0][W-1:0] obs, input logic [N:0][W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // start a frame, stream all words (optionally with gaps), then hand over to WRITE
    task automatic load_frame(input bit ramp, input int gap_max, input int rdy_delay,
                              output logic [N:0][W-1:0] exp_w);
        logic [W-1:0] w;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1'b1);
        chk("start_ready", cfg_ready, 1'b1);
        chk("start_err_clr", error, 1'b0);
        for (int i = 0; i <= N; i++) begin
            w = ramp ? W'(i * 10) : W'($urandom);
            exp_w[i] = w;
            repeat ($urandom_range(0, gap_max)) begin
                cfg_valid = 1'b0;
                cfg_data  = W'($urandom);
                start     = 1'($urandom_range(0, 1));
                tick();
            end
            cfg_valid = 1'b1;
            cfg_data  = w;
            tick();
        end
        cfg_valid = 1'b0;
        start     = 1'b0;
        chk("last_ready_low", cfg_ready, 1'b0);
        chk("collect_busy", busy, 1'b1);
        repeat (rdy_delay) begin
            write_rdy = 1'b0;
            write_ack = 1'($urandom_range(0, 1));
            tick();
        end
        write_ack = 1'b0;
        chk("wait_no_en", write_en, 1'b0);
        write_rdy = 1'b1;
        tick();
        write_rdy = 1'b0;
        chk("write_en_up", write_en, 1'b1);
    endtask

    // ack_at = WRITE cycle on which write_ack is raised (0 = never)
    task automatic finish_write(input int ack_at, input logic [N:0][W-1:0] exp_w);
        int en_cnt, done_cnt, exp_en;
        bit acked;
        en_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (write_en) en_cnt++;
            if (done) begin
                done_cnt++;
                chk("done_busy_low", busy, 1'b0);
            end
            write_ack = write_en && (en_cnt == ack_at);
            start     = write_en ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        write_ack = 1'b0;
        start     = 1'b0;
        acked  = (ack_at >= 1) && (ack_at <= TO);
        exp_en = acked ? ack_at : TO;
        chk_n("write_en_cycles", en_cnt, exp_en);
        chk_n("done_pulses", done_cnt, acked ? 1 : 0);
        chk("error_flag", error, !acked);
        chk("idle_busy", busy, 1'b0);
        chk_w("frame_data", w_data_out, exp_w);
    endtask

    initial begin
        logic [N:0][W-1:0] fr;

        // reset dominates start/cfg_valid
        reset = 1'b0;
        start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data = 16'hBEEF;
        tick();
        tick();
        chk("rst_ready", cfg_ready, 1'b0);
        chk("rst_en", write_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk_w("rst_data", w_data_out, '0);
        start = 1'b0;
        cfg_valid = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        chk("post_rst_idle", busy, 1'b0);

        // nominal ramp frame, ack on third WRITE cycle
        load_frame(1'b1, 0, 0, fr);
        finish_write(3, fr);

        // stalls on the stream and on write_rdy
        load_frame(1'b0, 3, 5, fr);
        finish_write($urandom_range(1, TO), fr);

        // timeout, then a recovery frame acked on the first WRITE cycle
        load_frame(1'b0, 2, $urandom_range(0, 3), fr);
        finish_write(0, fr);
        load_frame(1'b0, 1, 1, fr);
        finish_write(1, fr);

        // random frames, including late acks that must time out
        for (int k = 0; k < 6; k++) begin
            load_frame(1'b0, 2, $urandom_range(0, 4), fr);
            finish_write($urandom_range(0, TO + 2), fr);
        end

        // reset while write_en is high
        load_frame(1'b0, 1, 2, fr);
        tick();
        reset = 1'b0;
        tick();
        chk("midrst_en", write_en, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk_w("midrst_data", w_data_out, '0);
        reset = 1'b1;
        tick();
        load_frame(1'b0, 1, 1, fr);
        finish_write(2, fr);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
Initiator side of the config_mem write interface. It accepts configuration words one at a time on a valid/ready stream and assembles them into a frame of num_inputs+1 words. It then performs the write_en / write_rdy / write_ack handshake to commit the frame into config_mem. It sits between the tile's configuration stream and config_mem, and reports completion or ack timeout to the tile controller.

Parameters:
width, 16, data word width in bits
num_inputs, 8, highest word index; a frame is num_inputs+1 words
ack_timeout, 64, max cycles in WRITE waiting for write_ack; 0 disables the timeout

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
start  input  1  begin a new frame; sampled only in IDLE
cfg_valid  input  1  cfg_data valid
cfg_data  input  width  configuration word
cfg_ready  output  1  loader accepts cfg_data this cycle
write_en  output  1  write request to config_mem
write_rdy  input  1  config_mem idle and able to accept a write
write_ack  input  1  config_mem write complete
w_data_out  output  width x [num_inputs:0]  frame words to config_mem w_data_in
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after a successful commit
error  output  1  sticky ack-timeout flag

Behaviour:
- Reset (reset==0 at a clk edge) dominates every other input:
  - state=IDLE; cfg_ready, write_en, busy, done, error = 0; all w_data_out words = 0; word counter = 0; timeout counter = 0.
  - Reset mid-frame or mid-WRITE abandons the operation with no done pulse. write_en drops on the same edge.
- State machine: IDLE -> COLLECT -> WAIT_RDY -> WRITE -> IDLE.
- IDLE:
  - On start=1: go to COLLECT, clear error, clear word counter.
  - cfg_valid is ignored; cfg_ready=0.
- COLLECT:
  - cfg_ready=1 as a registered output, high for every cycle spent in COLLECT.
  - On cfg_valid&&cfg_ready: w_data_out[cnt] <= cfg_data, cnt <= cnt+1.
  - The transfer at cnt==num_inputs moves to WAIT_RDY; cfg_ready is 0 from the next cycle.
  - A cfg_valid gap stalls without loss. Words arrive in index order, 0 first.
  - The counter width is $clog2(num_inputs+1), with no wrap beyond num_inputs.
- WAIT_RDY:
  - Wait while write_rdy==0. write_ack is ignored here.
  - On write_rdy==1: go to WRITE, write_en=1 from the next cycle.
- WRITE:
  - write_en is held at 1. w_data_out is frozen while write_en is high.
  - On write_ack==1: write_en=0 on the next edge, done=1 for exactly that one cycle, then IDLE.
  - A write_ack that arrives on the first WRITE cycle is accepted.
- Timeout:
  - A counter increments each WRITE cycle.
  - If it reaches ack_timeout without write_ack: write_en=0, error=1, go to IDLE, no done pulse.
  - If write_ack and timeout occur in the same cycle, the ack wins.
- start asserted outside IDLE has no effect. start held high in IDLE after done begins a new frame on the next cycle.
- error stays 1 until the next accepted start or reset. w_data_out keeps the last frame after done.

Test Plan:
- Reset check: drive reset=0 for 2 cycles with start=1, cfg_valid=1 -> all outputs 0, all w_data_out=0; state stays IDLE once reset=1.
- Nominal frame: start, then 9 back-to-back words i*10 (i=0..8); write_rdy=1, ack after 3 WRITE cycles -> w_data_out[i]==i*10 and write_en high exactly 3 cycles. done is a single pulse; busy falls the same cycle done rises.
- Stalls: random cfg_valid gaps; write_rdy=0 for 5 cycles after the last word -> write_en stays 0 until write_rdy=1; data is in correct index order.
- Timeout: ack_timeout=4, never ack -> write_en drops after 4 WRITE cycles and error=1 with no done. A new start clears error and a good frame completes.
- Ignored events: start pulsed during COLLECT and WRITE, write_ack pulsed in WAIT_RDY -> no state change, no extra done.
- Reset mid-WRITE: reset=0 while write_en=1 -> write_en=0 next edge and w_data_out cleared. A following frame loads cleanly.
